sdio_reg_host: RTL and testbench
================================

# sdio_reg_host

Register-bus initiator for the SDIO controller's 8-bit register map. Converts burst requests (single or multi-beat, read or write, incrementing or fixed address) from a local controller (boot sequencer, test port or CPU bridge) into the single-cycle `reg_addr_wr` / `reg_data_wr` strobes the register file samples. It captures `reg_rdata` with the file's one-cycle read latency and returns read data through a valid/ready stream. It sits in the `sys_clk` domain, driving the register-bus inputs of the register file.

## Interface
Parameters:
- `WDOG_CYCLES`, default 255: write-data stall limit in cycles. Used only with `SDIO_REG_HOST_WDOG_EN`; range 1..255.

Ports:
- `sys_clk`, in, 1: block clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, 1: burst request valid.
- `req_ready`, out, 1: request accepted when `req_valid & req_ready`.
- `req_write`, in, 1: 1 = write burst, 0 = read burst.
- `req_addr`, in, 8: first register address.
- `req_len`, in, 4: number of beats minus 1, covering 1..16 beats.
- `req_inc`, in, 1: 1 = address increments per beat; 0 = address fixed.
- `wdata_valid`, in, 1: write-beat data valid.
- `wdata_ready`, out, 1: write beat consumed when `wdata_valid & wdata_ready`.
- `wdata`, in, 8: write-beat data.
- `rdata_valid`, out, 1: read-beat data valid.
- `rdata_ready`, in, 1: read beat consumed when `rdata_valid & rdata_ready`.
- `rdata`, out, 8: read-beat data.
- `done`, out, 1: one-cycle pulse when a burst finishes or aborts.
- `err`, out, 1: sticky abort flag. Cleared on the next request accept.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `reg_addr`, out, 8: register address to the register file.
- `reg_wdata`, out, 8: register write data to the register file.
- `reg_data_wr`, out, 1: one-cycle write strobe.
- `reg_addr_wr`, out, 1: one-cycle read-address strobe.
- `reg_rdata`, in, 8: read data. Valid the cycle after `reg_addr_wr`.

## Operation
- States: IDLE, WDATA, WSTB, RSTB, RCAP, RHOLD.
- **IDLE**
  - `req_ready` = 1.
  - On accept, latch `req_write`, `req_addr`, `req_len`, `req_inc` into `cur_addr`, `beats_left`, `inc`, `dir`, and clear `err`.
  - Next state: WDATA if write, RSTB if read.
- **WDATA**
  - `wdata_ready` = 1.
  - On handshake, register `reg_wdata` = `wdata` and `reg_addr` = `cur_addr`, then go to WSTB.
- **WSTB**
  - `reg_data_wr` = 1 for exactly this cycle.
  - Afterwards, if `beats_left` == 0, go to IDLE and pulse `done`.
  - Otherwise decrement `beats_left`, advance the address, and go to WDATA.
- **RSTB**
  - `reg_addr_wr` = 1 with `reg_addr` = `cur_addr` for exactly this cycle. Then go to RCAP.
- **RCAP**
  - Sample `reg_rdata` into `rdata`, then go to RHOLD.
- **RHOLD**
  - `rdata_valid` = 1 and `rdata` is held stable until `rdata_ready`.
  - On the handshake, finish as in WSTB, but the next beat goes to RSTB.
- Address advance: if `inc`, `cur_addr` = `cur_addr` + 1, modulo 256 (255 wraps to 0). If not `inc`, the address is unchanged.
- Strobes are mutually exclusive and never asserted in consecutive cycles for different addresses.
- `reg_addr` and `reg_wdata` hold their last value when idle.

## Timing
- Reset values: state IDLE; `req_ready` 1; every other output 0, including `reg_addr` and `reg_wdata`. The watchdog counter resets to 0.
- Reset asserted mid-burst takes effect at the next edge: the FSM goes to IDLE, no strobe is emitted in the following cycle, and `done` is not pulsed.
- Write beat: with the `wdata` handshake at edge N, `reg_data_wr` is high during cycle N+1.
  - Peak rate is 1 beat per 2 cycles.
- Read beat: `reg_addr_wr` is high in cycle N, `reg_rdata` is sampled at the end of N+1, and `rdata_valid` rises in N+2.
  - Peak rate is 1 beat per 3 cycles with `rdata_ready` tied high.
- `done` is high in the cycle after the final strobe (write) or after the final `rdata` handshake (read), coincident with the return to IDLE.
- A new request can be accepted in the same cycle that `done` is high.
- Burst order is strictly sequential. A read of 134 followed by 135 therefore yields a coherent DMA address, because the high byte is frozen by the 134 access.

## Configuration
- `SDIO_REG_HOST_WDOG_EN` defined: an 8-bit counter runs while in WDATA with `wdata_valid` low, and clears on any `wdata` handshake.
  - When the counter reaches `WDOG_CYCLES`, the burst aborts: go to IDLE, set `err`, pulse `done`, no strobe.
- `SDIO_REG_HOST_WDOG_EN` undefined: WDATA waits indefinitely, `err` is tied to 0, and the counter logic is absent.

## Structure
- `sdio_pkg` holds:
  - the `reg_host_state_t` enum (6 states);
  - `REG_HOST_LEN_W` = 4 and `REG_ADDR_W` = 8;
  - named address constants `REG_DMA_ADDR_LO` = 134 and `REG_DMA_ADDR_HI` = 135.
- No sub-module is required. The watchdog stays inline under the macro.

## Test plan
- Single write: addr 0x1D, data 0x04, len 0 → one `reg_data_wr` pulse with `reg_addr` 0x1D and `reg_wdata` 0x04; `done` one cycle later; exactly 1 strobe total.
- Incrementing write burst: addr 0x04, len 3, data 11/22/33/44 → strobes at 0x04..0x07 with matching data; `wdata` stalls of 5 cycles insert gaps but no extra strobes.
- Read burst with wrap: addr 0xFE, len 2, inc, model returns addr^0x5A → `reg_addr_wr` at 0xFE, 0xFF, 0x00; `rdata` 0xA4, 0xA5, 0x5A; `rdata_valid` exactly 2 cycles after each strobe.
- Fixed-address read with backpressure: addr 0x20, len 1, `req_inc` 0, `rdata_ready` held low 4 cycles → `rdata` stable while stalled; second `reg_addr_wr` only after the first handshake; both strobes at 0x20.
- Reset mid-read: assert `rst` the cycle after `reg_addr_wr` → next cycle all strobes 0, `busy` 0, `rdata_valid` 0, no `done`; a new request is accepted afterwards.
- Watchdog (macro on, `WDOG_CYCLES` 10): write request with `wdata_valid` held low → after 10 cycles `err` = 1, `done` pulses, no `reg_data_wr`; macro off → still waiting after 300 cycles.

Source files
------------

// File: rtl/sdio_pkg.sv
// sdio_pkg: shared types and constants for the SDIO controller register-bus host.
package sdio_pkg;

  localparam int unsigned REG_HOST_LEN_W = 4;
  localparam int unsigned REG_ADDR_W     = 8;

  // DMA address register pair; the low byte access freezes the high byte.
  localparam logic [REG_ADDR_W-1:0] REG_DMA_ADDR_LO = 8'd134;
  localparam logic [REG_ADDR_W-1:0] REG_DMA_ADDR_HI = 8'd135;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WSTB,
    ST_RSTB,
    ST_RCAP,
    ST_RHOLD
  } reg_host_state_t;

  // Next beat address: increment modulo 256, or hold for fixed bursts.
  function automatic logic [REG_ADDR_W-1:0] reg_addr_adv(input logic [REG_ADDR_W-1:0] addr,
                                                         input logic                  inc);
    return inc ? (addr + REG_ADDR_W'(1)) : addr;
  endfunction

endpackage

// File: rtl/sdio_reg_host.sv
// sdio_reg_host: burst request to single-cycle register-bus strobe initiator.
// Optional write-data watchdog enabled by defining SDIO_REG_HOST_WDOG_EN.
module sdio_reg_host
  import sdio_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [REG_ADDR_W-1:0]     req_addr,
  input  logic [REG_HOST_LEN_W-1:0] req_len,
  input  logic                      req_inc,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [REG_ADDR_W-1:0]     wdata,
  output logic                      rdata_valid,
  input  logic                      rdata_ready,
  output logic [REG_ADDR_W-1:0]     rdata,
  output logic                      done,
  output logic                      err,
  output logic                      busy,
  output logic [REG_ADDR_W-1:0]     reg_addr,
  output logic [REG_ADDR_W-1:0]     reg_wdata,
  output logic                      reg_data_wr,
  output logic                      reg_addr_wr,
  input  logic [REG_ADDR_W-1:0]     reg_rdata
);

  reg_host_state_t           state, state_nxt;
  logic [REG_ADDR_W-1:0]     cur_addr;
  logic [REG_ADDR_W-1:0]     addr_adv;
  logic [REG_HOST_LEN_W-1:0] beats_left;
  logic                      inc;
  logic                      dir;
  logic                      accept;
  logic                      beat_end;
  logic                      last_beat;
  logic                      wdog_abort;

  logic req_ready_nxt;
  logic wdata_ready_nxt;
  logic rdata_valid_nxt;
  logic reg_data_wr_nxt;
  logic reg_addr_wr_nxt;
  logic busy_nxt;
  logic done_nxt;

  if ((WDOG_CYCLES < 1) || (WDOG_CYCLES > 255)) begin : g_wdog_range_chk
    $error("sdio_reg_host: WDOG_CYCLES must be in 1..255");
  end

  assign accept    = (state == ST_IDLE) && req_valid;
  assign beat_end  = (state == ST_WSTB) || ((state == ST_RHOLD) && rdata_ready);
  assign last_beat = (beats_left == '0);
  assign addr_adv  = reg_addr_adv(cur_addr, inc);

`ifdef SDIO_REG_HOST_WDOG_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES);

  logic [7:0] wdog_cnt;
  logic       wdog_stall;

  assign wdog_stall = (state == ST_WDATA) && !wdata_valid;
  assign wdog_abort = wdog_stall && ((wdog_cnt + 8'd1) == WDOG_LIMIT);

  // Count consecutive write-data stall cycles; any other cycle restarts the count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if (wdog_stall) begin
      wdog_cnt <= wdog_cnt + 8'd1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  // Sticky abort flag, cleared when the next request is accepted.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (wdog_abort) begin
      err <= 1'b1;
    end
  end
`else
  assign wdog_abort = 1'b0;
  assign err        = 1'b0;
`endif

  // State and registered control outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      reg_data_wr <= 1'b0;
      reg_addr_wr <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready   <= req_ready_nxt;
      wdata_ready <= wdata_ready_nxt;
      rdata_valid <= rdata_valid_nxt;
      reg_data_wr <= reg_data_wr_nxt;
      reg_addr_wr <= reg_addr_wr_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // Next-state: one strobe per beat, next beat direction taken from the latched request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = req_write ? ST_WDATA : ST_RSTB;
      ST_WDATA: begin
        if (wdata_valid) begin
          state_nxt = ST_WSTB;
        end else if (wdog_abort) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WSTB, ST_RHOLD: begin
        if (beat_end) begin
          if (last_beat) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = dir ? ST_WDATA : ST_RSTB;
          end
        end
      end
      ST_RSTB:  state_nxt = ST_RCAP;
      ST_RCAP:  state_nxt = ST_RHOLD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so every control output leaves a flop.
  always_comb begin
    req_ready_nxt   = (state_nxt == ST_IDLE);
    wdata_ready_nxt = (state_nxt == ST_WDATA);
    rdata_valid_nxt = (state_nxt == ST_RHOLD);
    reg_data_wr_nxt = (state_nxt == ST_WSTB);
    reg_addr_wr_nxt = (state_nxt == ST_RSTB);
    busy_nxt        = (state_nxt != ST_IDLE);
    done_nxt        = (beat_end && last_beat) || wdog_abort;
  end

  // Burst context, register-bus address/data and captured read data.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      inc        <= 1'b0;
      dir        <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      rdata      <= '0;
    end else begin
      if (accept) begin
        cur_addr   <= req_addr;
        beats_left <= req_len;
        inc        <= req_inc;
        dir        <= req_write;
        if (!req_write) reg_addr <= req_addr;
      end
      if ((state == ST_WDATA) && wdata_valid) begin
        reg_wdata <= wdata;
        reg_addr  <= cur_addr;
      end
      if (beat_end && !last_beat) begin
        cur_addr   <= addr_adv;
        beats_left <= beats_left - REG_HOST_LEN_W'(1);
        if (!dir) reg_addr <= addr_adv;
      end
      if (state == ST_RCAP) rdata <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_sdio_reg_host.sv
// tb_sdio_reg_host: directed bench with a transaction-level scoreboard for sdio_reg_host.
// Define SDIO_REG_HOST_WDOG_EN to exercise the write-data watchdog.
module tb_sdio_reg_host;
  import sdio_pkg::*;

  localparam int unsigned WDOG = 10;

  logic       sys_clk;
  logic       rst;
  logic       req_valid, req_ready, req_write, req_inc;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_ready;
  logic [7:0] rdata;
  logic       done, err, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_data_wr, reg_addr_wr;

  sdio_reg_host #(.WDOG_CYCLES(WDOG)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_inc     (req_inc),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_data_wr (reg_data_wr),
    .reg_addr_wr (reg_addr_wr),
    .reg_rdata   (reg_rdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Register file model: data is addr ^ 0x5A one cycle after the read strobe, junk otherwise.
  initial reg_rdata = 8'hEE;
  always @(posedge sys_clk) reg_rdata <= reg_addr_wr ? (reg_addr ^ 8'h5A) : 8'hEE;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } stb_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rdx_t;

  stb_t exp_q[$];
  rdx_t rd_q[$];
  logic [7:0] wbuf [16];

  int n_checks = 0;
  int n_fail   = 0;
  int done_due = -1;
  int acc_cyc  = 0;
  int last_rstb = -100;

  logic [7:0] wr_addr_log [256];
  logic [7:0] wr_data_log [256];
  int         wr_cyc_log  [256];
  int         wr_cnt = 0;
  logic [7:0] rd_addr_log [256];
  int         rstb_cyc_log[256];
  int         rd_cnt = 0;
  logic [7:0] hs_data_log [256];
  int         hs_cyc_log  [256];
  int         hs_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return req_ready;
      1:       return wdata_ready;
      2:       return rdata_valid;
      3:       return done;
      default: return reg_addr_wr;
    endcase
  endfunction

  // Poll negedges until the selected output is high, bounded to 200 cycles.
  task automatic wait_hi(input int sel, input string name);
    int n = 0;
    @(negedge sys_clk);
    while (!get_sig(sel) && n < 200) begin
      n++;
      @(negedge sys_clk);
    end
    if (!get_sig(sel)) chk({"wait_", name}, 32'(get_sig(sel)), 32'(1));
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [3:0] len,
                        input logic inc, input bit push);
    logic [7:0] ad;
    stb_t e;
    ad = a;
    if (push) begin
      for (int i = 0; i <= int'(len); i++) begin
        e.wr   = wr;
        e.addr = ad;
        e.data = wr ? wbuf[i] : 8'h00;
        e.last = (i == int'(len));
        exp_q.push_back(e);
        if (inc) ad = ad + 8'd1;
      end
    end
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    req_inc   = inc;
    req_valid = 1'b1;
    wait_hi(0, "req_ready");
    acc_cyc = cyc;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_wdata(input logic [7:0] d, input int stall);
    repeat (stall) @(posedge sys_clk);
    #1;
    wdata       = d;
    wdata_valid = 1'b1;
    wait_hi(1, "wdata_ready");
    @(posedge sys_clk); #1;
    wdata_valid = 1'b0;
  endtask

  task automatic read_beat(input int hold);
    if (hold == 0) begin
      rdata_ready = 1'b1;
      wait_hi(2, "rdata_valid");
    end else begin
      wait_hi(2, "rdata_valid");
      repeat (hold) @(posedge sys_clk);
      #1;
      rdata_ready = 1'b1;
      @(negedge sys_clk);
    end
    @(posedge sys_clk); #1;
    rdata_ready = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] a, input logic [3:0] len, input logic inc,
                             input int stall);
    do_req(1'b1, a, len, inc, 1'b1);
    for (int i = 0; i <= int'(len); i++) send_wdata(wbuf[i], stall);
    wait_hi(3, "wr_done");
    @(posedge sys_clk); #1;
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [3:0] len, input logic inc,
                            input int hold);
    do_req(1'b0, a, len, inc, 1'b1);
    for (int i = 0; i <= int'(len); i++) read_beat(hold);
    wait_hi(3, "rd_done");
    @(posedge sys_clk); #1;
  endtask

  // Scoreboard: every cycle out of reset, compare strobes, read data and done against the model.
  task automatic monitor();
    logic       prev_stb, prev_rv, prev_hs, cur_stb;
    logic [7:0] prev_rd;
    stb_t       e;
    rdx_t       r;
    prev_stb = 1'b0;
    prev_rv  = 1'b0;
    prev_hs  = 1'b0;
    prev_rd  = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        prev_stb = 1'b0;
        prev_rv  = 1'b0;
        prev_hs  = 1'b0;
        continue;
      end
      cur_stb = reg_data_wr | reg_addr_wr;
      chk("done", 32'(done), 32'(cyc == done_due));
      chk("strobe_excl", 32'(reg_data_wr & reg_addr_wr), 32'(0));
      chk("strobe_gap", 32'(prev_stb & cur_stb), 32'(0));
      if (reg_data_wr) begin
        chk("wr_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_kind", 32'(e.wr), 32'(1));
          chk("wr_addr", 32'(reg_addr), 32'(e.addr));
          chk("wr_data", 32'(reg_wdata), 32'(e.data));
          if (e.last) done_due = cyc + 1;
        end
        wr_addr_log[wr_cnt] = reg_addr;
        wr_data_log[wr_cnt] = reg_wdata;
        wr_cyc_log[wr_cnt]  = cyc;
        wr_cnt++;
      end
      if (reg_addr_wr) begin
        chk("rd_expected", 32'(exp_q.size() != 0), 32'(1));
        r.last = 1'b1;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_kind", 32'(e.wr), 32'(0));
          chk("rd_addr", 32'(reg_addr), 32'(e.addr));
          r.last = e.last;
        end
        r.data = reg_addr ^ 8'h5A;
        rd_q.push_back(r);
        last_rstb = cyc;
        rd_addr_log[rd_cnt]  = reg_addr;
        rstb_cyc_log[rd_cnt] = cyc;
        rd_cnt++;
      end
      if (rdata_valid && !prev_rv) chk("rvalid_lat", 32'(cyc - last_rstb), 32'(2));
      if (rdata_valid && prev_rv && !prev_hs) chk("rdata_stable", 32'(rdata), 32'(prev_rd));
      if (rdata_valid && rdata_ready) begin
        chk("rdata_expected", 32'(rd_q.size() != 0), 32'(1));
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          chk("rdata", 32'(rdata), 32'(r.data));
          if (r.last) done_due = cyc + 1;
        end
        hs_data_log[hs_cnt] = rdata;
        hs_cyc_log[hs_cnt]  = cyc;
        hs_cnt++;
      end
      prev_stb = cur_stb;
      prev_rv  = rdata_valid;
      prev_hs  = rdata_valid & rdata_ready;
      prev_rd  = rdata;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b, h;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 8'h00;
    req_len     = 4'h0;
    req_inc     = 1'b0;
    wdata_valid = 1'b0;
    wdata       = 8'h00;
    rdata_ready = 1'b0;
    for (int i = 0; i < 16; i++) wbuf[i] = 8'h00;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_wdata_ready", 32'(wdata_ready), 32'(0));
    chk("rst_rdata_valid", 32'(rdata_valid), 32'(0));
    chk("rst_reg_data_wr", 32'(reg_data_wr), 32'(0));
    chk("rst_reg_addr_wr", 32'(reg_addr_wr), 32'(0));
    chk("rst_reg_addr", 32'(reg_addr), 32'(0));
    chk("rst_reg_wdata", 32'(reg_wdata), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Single write
    wbuf[0] = 8'h04;
    b = wr_cnt;
    do_req(1'b1, 8'h1D, 4'd0, 1'b1, 1'b1);
    chk("t1_busy", 32'(busy), 32'(1));
    send_wdata(8'h04, 0);
    wait_hi(3, "t1_done");
    chk("t1_nstb", 32'(wr_cnt - b), 32'(1));
    chk("t1_addr", 32'(wr_addr_log[b]), 32'(8'h1D));
    chk("t1_data", 32'(wr_data_log[b]), 32'(8'h04));
    chk("t1_done_lat", 32'(cyc - wr_cyc_log[b]), 32'(1));
    @(posedge sys_clk); #1;
    chk("t1_idle_addr", 32'(reg_addr), 32'(8'h1D));

    // Incrementing write burst with 5-cycle data stalls
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    b = wr_cnt;
    write_burst(8'h04, 4'd3, 1'b1, 5);
    chk("t2_nstb", 32'(wr_cnt - b), 32'(4));
    chk("t2_addr0", 32'(wr_addr_log[b]), 32'(8'h04));
    chk("t2_addr3", 32'(wr_addr_log[b+3]), 32'(8'h07));
    chk("t2_data1", 32'(wr_data_log[b+1]), 32'(8'h22));
    chk("t2_data3", 32'(wr_data_log[b+3]), 32'(8'h44));

    // Read burst wrapping past 0xFF
    b = rd_cnt; h = hs_cnt;
    read_burst(8'hFE, 4'd2, 1'b1, 0);
    chk("t3_nstb", 32'(rd_cnt - b), 32'(3));
    chk("t3_addr2", 32'(rd_addr_log[b+2]), 32'(8'h00));
    chk("t3_data0", 32'(hs_data_log[h]), 32'(8'hA4));
    chk("t3_data1", 32'(hs_data_log[h+1]), 32'(8'hA5));
    chk("t3_data2", 32'(hs_data_log[h+2]), 32'(8'h5A));

    // Fixed-address read with 4 cycles of backpressure
    b = rd_cnt; h = hs_cnt;
    read_burst(8'h20, 4'd1, 1'b0, 4);
    chk("t4_nstb", 32'(rd_cnt - b), 32'(2));
    chk("t4_addr1", 32'(rd_addr_log[b+1]), 32'(8'h20));
    chk("t4_data1", 32'(hs_data_log[h+1]), 32'(8'h7A));
    chk("t4_order", 32'(rstb_cyc_log[b+1] - hs_cyc_log[h]), 32'(1));

    // Write-data watchdog
    wbuf[0] = 8'h99;
    b = wr_cnt;
`ifdef SDIO_REG_HOST_WDOG_EN
    do_req(1'b1, 8'h40, 4'd0, 1'b1, 1'b0);
    done_due = acc_cyc + 1 + int'(WDOG);
    wait_hi(3, "wdog_done");
    chk("wdog_lat", 32'(cyc - acc_cyc), 32'(1 + int'(WDOG)));
    chk("wdog_err", 32'(err), 32'(1));
    chk("wdog_nostb", 32'(wr_cnt - b), 32'(0));
    @(posedge sys_clk); #1;
    chk("wdog_idle", 32'(busy), 32'(0));
`else
    do_req(1'b1, 8'h40, 4'd0, 1'b1, 1'b1);
    repeat (300) @(posedge sys_clk);
    #1;
    chk("nowdog_busy", 32'(busy), 32'(1));
    chk("nowdog_wready", 32'(wdata_ready), 32'(1));
    chk("nowdog_err", 32'(err), 32'(0));
    chk("nowdog_nostb", 32'(wr_cnt - b), 32'(0));
    send_wdata(8'h99, 0);
    wait_hi(3, "nowdog_done");
    @(posedge sys_clk); #1;
`endif

    // Reset in the cycle after the read strobe
    do_req(1'b0, 8'h30, 4'd1, 1'b1, 1'b1);
    chk("t6_err_clr", 32'(err), 32'(0));
    wait_hi(4, "t6_rstb");
    @(posedge sys_clk); #1;
    rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    done_due = -1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(negedge sys_clk);
    chk("t6_data_wr", 32'(reg_data_wr), 32'(0));
    chk("t6_addr_wr", 32'(reg_addr_wr), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_rvalid", 32'(rdata_valid), 32'(0));
    chk("t6_done", 32'(done), 32'(0));
    chk("t6_req_ready", 32'(req_ready), 32'(1));
    @(posedge sys_clk); #1;

    // DMA address pair read after reset
    b = rd_cnt; h = hs_cnt;
    read_burst(REG_DMA_ADDR_LO, 4'd1, 1'b1, 0);
    chk("t7_addr0", 32'(rd_addr_log[b]), 32'(8'd134));
    chk("t7_addr1", 32'(rd_addr_log[b+1]), 32'(8'd135));
    chk("t7_data0", 32'(hs_data_log[h]), 32'(8'hDC));
    chk("t7_data1", 32'(hs_data_log[h+1]), 32'(8'hDD));

    repeat (3) @(posedge sys_clk);
    #1;
    chk("end_exp_q", 32'(exp_q.size()), 32'(0));
    chk("end_rd_q", 32'(rd_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
